sum_frame_accum: RTL



---
 rtl/sum_frame_pkg.sv | 15 +
 rtl/sum_frame_acc_core.sv | 68 ++++++
 rtl/sum_frame_accum.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sum_frame_pkg.sv
// Shared types and helpers for the sum frame accumulator.
// The SUM_FRAME_ACCUM_SAT_EN build option is consumed by sum_frame_acc_core.
package sum_frame_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Width of a beat counter able to hold 0..frame_len.
  function automatic int cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/sum_frame_acc_core.sv
// Per-frame accumulator: running total, beat count, overflow flag, final-beat detect.
// Define SUM_FRAME_ACCUM_SAT_EN to clamp the total on overflow instead of wrapping.
module sum_frame_acc_core
  import sum_frame_pkg::*;
#(
  parameter int W         = 32,
  parameter int ACC_W     = 40,
  parameter int FRAME_LEN = 8,
  localparam int CNT_W    = cnt_width(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             last_beat,
  output logic [ACC_W-1:0] res_total,
  output logic [CNT_W-1:0] res_count,
  output logic             res_ovf
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum_w;

  always_comb begin
    sum_w   = {1'b0, acc_q} + {{(ACC_W + 1 - W){1'b0}}, in_data};
    res_ovf = ovf_q | sum_w[ACC_W];
`ifdef SUM_FRAME_ACCUM_SAT_EN
    // Once the frame has overflowed the total pins at full scale.
    res_total = res_ovf ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
    res_total = sum_w[ACC_W-1:0];
`endif
    res_count = cnt_q + CNT_W'(1);
    last_beat = (res_count == CNT_W'(FRAME_LEN)) || in_last;

    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (accept) begin
      // A final beat clears the frame so the next beat starts fresh without a bubble.
      if (last_beat) begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = res_total;
        cnt_d = res_count;
        ovf_d = res_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/sum_frame_accum.sv
// Frame accumulator stage: sums beats into per-frame totals behind a 2-deep result buffer.
// Build option SUM_FRAME_ACCUM_SAT_EN selects saturating totals (see sum_frame_acc_core).
module sum_frame_accum
  import sum_frame_pkg::*;
#(
  parameter int W         = 32,
  parameter int ACC_W     = 40,
  parameter int FRAME_LEN = 8,
  localparam int CNT_W    = cnt_width(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef struct packed {
    logic [ACC_W-1:0] total;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } result_t;

  // Handshake: a transfer happens on a clock edge where valid && ready are both high.
  // valid never waits on ready, payload holds while valid && !ready, and in_ready is
  // a flop driven only from state, so out_ready has no combinational path to it.
  state_e  state_q, state_d;
  logic    in_ready_q, in_ready_d;
  result_t out_q, out_d, hold_q, hold_d;
  logic    out_valid_q, out_valid_d;
  logic    hold_valid_q, hold_valid_d;

  logic             accept, out_buf_ready, last_beat;
  logic [ACC_W-1:0] res_total;
  logic [CNT_W-1:0] res_count;
  logic             res_ovf;
  result_t          res;

  assign accept        = in_valid && in_ready_q;
  assign out_buf_ready = !out_valid_q || out_ready;
  assign res           = '{total: res_total, count: res_count, ovf: res_ovf};

  sum_frame_acc_core #(
    .W        (W),
    .ACC_W    (ACC_W),
    .FRAME_LEN(FRAME_LEN)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept   (accept),
    .in_data  (in_data),
    .in_last  (in_last),
    .last_beat(last_beat),
    .res_total(res_total),
    .res_count(res_count),
    .res_ovf  (res_ovf)
  );

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      ACCUM: begin
        if (accept && last_beat) begin
          if (out_buf_ready) begin
            out_d       = res;
            out_valid_d = 1'b1;
          end else begin
            hold_d       = res;
            hold_valid_d = 1'b1;
            state_d      = FULL;
          end
        end
      end
      FULL: begin
        if (out_buf_ready) begin
          out_d        = hold_q;
          out_valid_d  = 1'b1;
          hold_valid_d = 1'b0;
          state_d      = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
    in_ready_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ACCUM;
      in_ready_q   <= 1'b1;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_total = out_q.total;
  assign out_count = out_q.count;
  assign out_ovf   = out_q.ovf;

endmodule
